// File: rtl/timeout_guard_if.sv
// timeout_guard_if: request/response handshake bundle for timeout_guard.
//   req_valid/req_duration/req_ready : request channel (master -> guard)
//   rsp_valid/rsp_status/rsp_retries/rsp_ready : response channel (guard -> master)
// master modport is the requesting side, slave modport is the guard.
interface timeout_guard_if #(
  parameter int unsigned DUR_W = 16
);
  logic             req_valid;
  logic [DUR_W-1:0] req_duration;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [1:0]       rsp_retries;

  modport master (
    output req_valid, req_duration, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_retries
  );

  modport slave (
    input  req_valid, req_duration, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_retries
  );
endinterface

// File: rtl/timeout_guard.sv
// timeout_guard: supervises one compute-engine operation with a countdown
// timer, retrying on timeout up to MAX_RETRY times.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   bus (slave)       request/response handshake (see timeout_guard_if)
//   op_start/op_abort one-cycle pulses to the engine; op_done from engine
//   cancel            user cancel of the in-flight operation
//   tmr_start         one-cycle start pulse to the timer
//   tmr_duration      timer budget, held from accept until next request
//   tmr_timeout       timer expiry level
//   led_busy          high while a request is in flight
// rsp_status: 00 OK, 01 TIMEOUT, 10 CANCEL, 11 BADARG.
module timeout_guard #(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned DUR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  timeout_guard_if.slave   bus,
  output logic             op_start,
  input  logic             op_done,
  output logic             op_abort,
  input  logic             cancel,
  output logic             tmr_start,
  output logic [DUR_W-1:0] tmr_duration,
  input  logic             tmr_timeout,
  output logic             led_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_ABORT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_CANCEL  = 2'b10,
    ST_BADARG  = 2'b11
  } status_t;

  state_t     state, state_nxt;
  status_t    status_q;
  logic [1:0] retries_q;
  logic       cause_cancel_q;
  logic       tmo_q;
  logic       tmo_edge;
  logic       retry_ok;
  logic       req_zero;

  // A timeout level left high from an earlier expiry must not count, so only
  // a fresh rising edge relative to the registered copy is acted upon.
  assign tmo_edge = tmr_timeout & ~tmo_q;
  assign retry_ok = (32'(retries_q) < MAX_RETRY);
  assign req_zero = (bus.req_duration == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nxt = req_zero ? S_RESP : S_ARM;
      S_ARM:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (op_done)       state_nxt = S_RESP;
        else if (cancel)   state_nxt = S_ABORT;
        else if (tmo_edge) state_nxt = S_ABORT;
      end
      S_ABORT: state_nxt = (!cause_cancel_q && retry_ok) ? S_ARM : S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs (Moore); response fields are only presented in RESP
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_status  = '0;
    bus.rsp_retries = '0;
    op_start        = 1'b0;
    op_abort        = 1'b0;
    tmr_start       = 1'b0;
    led_busy        = 1'b0;
    case (state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_ARM: begin
        op_start  = 1'b1;
        tmr_start = 1'b1;
        led_busy  = 1'b1;
      end
      S_WAIT:  led_busy = 1'b1;
      S_ABORT: begin
        op_abort = 1'b1;
        led_busy = 1'b1;
      end
      S_RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_status  = status_q;
        bus.rsp_retries = retries_q;
      end
      default: bus.req_ready = 1'b1;
    endcase
  end

  // Datapath: duration, retry count, abort cause, status, timeout edge reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_duration   <= '0;
      retries_q      <= '0;
      cause_cancel_q <= 1'b0;
      status_q       <= ST_OK;
      tmo_q          <= 1'b0;
    end else begin
      tmo_q <= (state == S_ARM) ? 1'b0 : tmr_timeout;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            tmr_duration <= bus.req_duration;
            retries_q    <= '0;
            if (req_zero) status_q <= ST_BADARG;
          end
        end
        S_WAIT: begin
          if (op_done)       status_q       <= ST_OK;
          else if (cancel)   cause_cancel_q <= 1'b1;
          else if (tmo_edge) cause_cancel_q <= 1'b0;
        end
        S_ABORT: begin
          if (!cause_cancel_q && retry_ok) begin
            if (retries_q != 2'd3) retries_q <= retries_q + 2'd1;
          end else begin
            status_q <= cause_cancel_q ? ST_CANCEL : ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timeout_guard.sv
module tb_timeout_guard;

  logic        clk;
  logic        rst_n;
  logic        op_start, op_done, op_abort, cancel;
  logic        tmr_start, tmr_timeout, led_busy;
  logic [15:0] tmr_duration;

  int checks;
  int failures;

  timeout_guard_if #(.DUR_W(16)) bus ();

  timeout_guard #(.MAX_RETRY(2), .DUR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .op_start     (op_start),
    .op_done      (op_done),
    .op_abort     (op_abort),
    .cancel       (cancel),
    .tmr_start    (tmr_start),
    .tmr_duration (tmr_duration),
    .tmr_timeout  (tmr_timeout),
    .led_busy     (led_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected packing: {req_ready, op_start, op_abort, tmr_start, rsp_valid,
  //                    rsp_status[1:0], rsp_retries[1:0], led_busy}
  typedef struct {
    logic        rv;
    logic [15:0] dur;
    logic        done;
    logic        can;
    logic        to;
    logic        rr;
    logic [9:0]  exp;
  } vec_t;

  localparam logic [9:0] E_IDLE = 10'b1_0_0_0_0_00_00_0;
  localparam logic [9:0] E_ARM  = 10'b0_1_0_1_0_00_00_1;
  localparam logic [9:0] E_WAIT = 10'b0_0_0_0_0_00_00_1;
  localparam logic [9:0] E_ABRT = 10'b0_0_1_0_0_00_00_1;

  vec_t vecs[$];

  function automatic logic [9:0] e_resp(input logic [1:0] st, input logic [1:0] rt);
    return {5'b00001, st, rt, 1'b0};
  endfunction

  function automatic logic [9:0] actual();
    return {bus.req_ready, op_start, op_abort, tmr_start, bus.rsp_valid,
            bus.rsp_status, bus.rsp_retries, led_busy};
  endfunction

  task automatic row(input logic rv, input logic [15:0] dur, input logic done,
                     input logic can, input logic to, input logic rr,
                     input logic [9:0] exp);
    vec_t v;
    v.rv = rv; v.dur = dur; v.done = done; v.can = can; v.to = to; v.rr = rr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = 1'b0; bus.req_duration = '0; bus.rsp_ready = 1'b0;
    op_done = 1'b0; cancel = 1'b0; tmr_timeout = 1'b0;
  endtask

  // One full request with a simple timer model: the timer restarts on
  // tmr_start, its level drops the cycle after, and it rises again after
  // tmo_after cycles. The engine finishes done_delay cycles after op_start on
  // try number done_try (0 = never).
  task automatic run_op(input logic [15:0] dur, input int done_try, input int done_delay,
                        input int tmo_after, output int starts, output int aborts,
                        output logic [1:0] st, output logic [1:0] rt, output logic ok,
                        output logic lat_ok, output logic dur_ok);
    int tries, cyc, t_cnt;
    starts = 0; aborts = 0; tries = 0; cyc = 0; t_cnt = 0;
    st = '0; rt = '0; ok = 1'b0; dur_ok = 1'b1;
    bus.req_valid = 1'b1; bus.req_duration = dur;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat_ok = op_start;
    for (int k = 0; k < 600; k++) begin
      if (op_start) begin
        starts++; tries++; cyc = 0; t_cnt = tmo_after;
      end else begin
        cyc++;
        if (t_cnt > 0) t_cnt--;
      end
      if (op_abort) aborts++;
      if (led_busy && tmr_duration != dur) dur_ok = 1'b0;
      if (!op_start) tmr_timeout = (tries > 0 && t_cnt == 0);
      op_done = (done_try != 0 && tries == done_try && cyc == done_delay && !op_start);
      if (bus.rsp_valid) begin
        st = bus.rsp_status; rt = bus.rsp_retries; ok = 1'b1;
        op_done = 1'b0; tmr_timeout = 1'b0; bus.rsp_ready = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  int          n_st, n_ab;
  logic [1:0]  r_st, r_rt;
  logic        r_ok, r_lat, r_dur;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, actual()}, {22'd0, E_IDLE});
    chk("reset_tmr_duration", {16'd0, tmr_duration}, 32'd0);
    rst_n = 1'b1;

    // cycle-by-cycle vectors: inputs for the cycle, outputs expected in it
    row(0, 0, 0, 0, 1, 0, E_IDLE);          // timeout level high while idle
    row(1, 0, 0, 0, 1, 0, E_IDLE);          // zero-duration request
    row(0, 0, 0, 0, 1, 0, e_resp(2'b11, 0));
    row(0, 0, 0, 0, 1, 1, e_resp(2'b11, 0));
    row(0, 0, 0, 0, 1, 0, E_IDLE);
    row(1, 5, 0, 0, 1, 0, E_IDLE);          // request with stale timeout high
    row(0, 0, 0, 0, 1, 0, E_ARM);
    row(0, 0, 0, 0, 0, 0, E_WAIT);          // no spurious abort
    row(0, 0, 0, 0, 0, 0, E_WAIT);
    row(0, 0, 1, 1, 1, 0, E_WAIT);          // done+cancel+edge -> OK
    row(0, 0, 0, 0, 1, 0, e_resp(2'b00, 0));
    row(0, 0, 0, 0, 0, 1, e_resp(2'b00, 0));
    row(0, 0, 1, 1, 0, 0, E_IDLE);          // done/cancel outside WAIT ignored
    row(1, 7, 0, 0, 0, 0, E_IDLE);
    row(0, 0, 0, 0, 0, 0, E_ARM);
    row(0, 0, 0, 1, 1, 0, E_WAIT);          // cancel+edge -> CANCEL
    row(0, 0, 0, 0, 1, 0, E_ABRT);
    row(0, 0, 0, 0, 0, 1, e_resp(2'b10, 0)); // no retry on cancel
    row(1, 3, 0, 0, 0, 0, E_IDLE);
    row(0, 0, 0, 0, 0, 0, E_ARM);
    row(0, 0, 0, 0, 1, 0, E_WAIT);          // timeout edge on first try
    row(0, 0, 0, 0, 1, 0, E_ABRT);
    row(0, 0, 0, 0, 1, 0, E_ARM);           // retry
    row(0, 0, 0, 0, 0, 0, E_WAIT);
    row(0, 0, 1, 0, 0, 0, E_WAIT);          // done on second try
    row(0, 0, 0, 0, 0, 1, e_resp(2'b00, 1));
    row(0, 0, 0, 0, 0, 0, E_IDLE);

    foreach (vecs[i]) begin
      bus.req_valid = vecs[i].rv; bus.req_duration = vecs[i].dur;
      op_done = vecs[i].done; cancel = vecs[i].can;
      tmr_timeout = vecs[i].to; bus.rsp_ready = vecs[i].rr;
      #1;
      chk($sformatf("vec[%0d]", i), {22'd0, actual()}, {22'd0, vecs[i].exp});
      @(posedge clk); #1;
    end
    clear_inputs();

    // nominal: duration 100, done 40 cycles after op_start
    run_op(16'd100, 1, 40, 100, n_st, n_ab, r_st, r_rt, r_ok, r_lat, r_dur);
    chk("nom_resp_seen", {31'd0, r_ok}, 32'd1);
    chk("nom_latency", {31'd0, r_lat}, 32'd1);
    chk("nom_tmr_duration", {31'd0, r_dur}, 32'd1);
    chk("nom_status", {30'd0, r_st}, 32'd0);
    chk("nom_retries", {30'd0, r_rt}, 32'd0);
    chk("nom_starts", n_st, 32'd1);
    chk("nom_aborts", n_ab, 32'd0);
    chk("nom_back_idle", {31'd0, bus.req_ready}, 32'd1);

    // three timeouts, no completion -> TIMEOUT after 2 retries
    run_op(16'd10, 0, 0, 5, n_st, n_ab, r_st, r_rt, r_ok, r_lat, r_dur);
    chk("tmo_resp_seen", {31'd0, r_ok}, 32'd1);
    chk("tmo_status", {30'd0, r_st}, 32'd1);
    chk("tmo_retries", {30'd0, r_rt}, 32'd2);
    chk("tmo_starts", n_st, 32'd3);
    chk("tmo_aborts", n_ab, 32'd3);

    // timeout on first try, done on second
    run_op(16'd10, 2, 3, 5, n_st, n_ab, r_st, r_rt, r_ok, r_lat, r_dur);
    chk("retry_status", {30'd0, r_st}, 32'd0);
    chk("retry_retries", {30'd0, r_rt}, 32'd1);
    chk("retry_starts", n_st, 32'd2);
    chk("retry_aborts", n_ab, 32'd1);

    // reset during WAIT: outputs return to reset values at once
    bus.req_valid = 1'b1; bus.req_duration = 16'd50;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_busy", {31'd0, led_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {22'd0, actual()}, {22'd0, E_IDLE});
    chk("rst_async_duration", {16'd0, tmr_duration}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_hold[%0d]", c), {30'd0, op_abort, bus.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_idle", {22'd0, actual()}, {22'd0, E_IDLE});

    // response held for 5 cycles with rsp_ready low
    bus.req_valid = 1'b1; bus.req_duration = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_resp[%0d]", c), {22'd0, actual()}, {22'd0, e_resp(2'b11, 0)});
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("hold_resp_last", {22'd0, actual()}, {22'd0, e_resp(2'b11, 0)});
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hold_back_idle", {22'd0, actual()}, {22'd0, E_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timeout_guard.md
TIMEOUT_GUARD -- requirements
Module: timeout_guard

Interface
REQ-001 Parameter: MAX_RETRY, 2, retries after first timeout before failing (0..3).
REQ-002 Parameter: DUR_W, 16, width of duration fields.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  operation request.
REQ-006 req_duration  input  DUR_W  timeout budget passed to the countdown timer.
REQ-007 req_ready  output  1  guard can accept a request.
REQ-008 op_start  output  1  one-cycle start pulse to compute engine.
REQ-009 op_done  input  1  engine completion, single-cycle or level.
REQ-010 op_abort  output  1  one-cycle abort pulse to the engine.
REQ-011 cancel  input  1  user cancel of the in-flight operation.
REQ-012 tmr_start  output  1  one-cycle start pulse to the countdown timer.
REQ-013 tmr_duration  output  DUR_W  duration to the timer, held stable from ARM until next request.
REQ-014 tmr_timeout  input  1  timer expiry level (may stay high after expiry).
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  response consumed.
REQ-017 rsp_status  output  2  00 OK, 01 TIMEOUT, 10 CANCEL, 11 BADARG.
REQ-018 rsp_retries  output  2  retries consumed for this request.
REQ-019 led_busy  output  1  high while a request is in flight.

Function
REQ-020 FSM states SHALL be IDLE, ARM, WAIT, ABORT, RESP.
REQ-021 IDLE: req_ready=1; on req_valid, latch req_duration into tmr_duration, clear retry count, go ARM next cycle.
REQ-022 Request with req_duration=0: go RESP with status BADARG, no op_start/tmr_start.
REQ-023 ARM: exactly one cycle, op_start=1 and tmr_start=1 in the same cycle; then WAIT.
REQ-024 tmr_timeout SHALL be rising-edge detected against a registered copy; a level held high from a prior expiry never counts; the edge register is cleared in ARM.
REQ-025 WAIT priority: op_done > cancel > timeout edge.
REQ-026 WAIT, op_done: go RESP, status OK, rsp_retries = retries used.
REQ-027 WAIT, cancel: go ABORT, recorded cause CANCEL.
REQ-028 WAIT, timeout edge: go ABORT, recorded cause TIMEOUT.
REQ-029 ABORT: one cycle, op_abort=1; cause TIMEOUT with retries<MAX_RETRY -> increment retries, go ARM; else go RESP.
REQ-030 Retry count SHALL saturate at 3; MAX_RETRY=0 means first timeout fails.
REQ-031 RESP: rsp_valid=1, status/retries stable until rsp_ready sampled high, then IDLE next cycle.
REQ-032 op_done or cancel arriving outside WAIT SHALL be ignored.
REQ-033 led_busy = state in {ARM, WAIT, ABORT}.
REQ-034 Request-to-op_start latency: 2 cycles (accept edge, ARM).

Reset
REQ-035 On rst_n low, asynchronously: state IDLE, retries 0, tmr_duration 0, edge register 0, all outputs 0 except req_ready=1.
REQ-036 Reset mid-operation SHALL drop the request silently; no op_abort or rsp_valid is issued.

Verification
REQ-037 req_duration=100, op_done 40 cycles after op_start -> rsp_status 00, rsp_retries 0, one op_start, no op_abort.
REQ-038 MAX_RETRY=2, tmr_timeout rising three times, no op_done -> 3 op_start, 3 op_abort, rsp_status 01, rsp_retries 2.
REQ-039 Timeout edge on 1st try, op_done on 2nd -> rsp_status 00, rsp_retries 1.
REQ-040 op_done, cancel and timeout edge in same WAIT cycle -> status 00; cancel+timeout only -> status 10, no retry.
REQ-041 req_duration=0 -> rsp_status 11 two cycles later, op_start/tmr_start never asserted; tmr_timeout held high before request -> no spurious ABORT.
REQ-042 rst_n low during WAIT, rsp_ready held low in RESP 5 cycles -> outputs return to reset values immediately; rsp_valid stays 1 for all 5 cycles, then IDLE.
